// File: rtl/cluster_frame_packer.sv
// cluster_frame_packer: captures eight clusters on the finder's latch strobe
// and streams them as four 30-bit link words, two clusters per word. An active
// slot (A) feeds the link while a one-frame holding slot (B) absorbs strobe
// jitter; frames arriving with both slots full are dropped and counted, and the
// next frame to start carries the ovf flag in its first word.
module cluster_frame_packer #(
  parameter int                   MXCLUSTERS  = 8,
  parameter int                   MXADRBITS   = 11,
  parameter int                   MXCNTBITS   = 3,
  parameter logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FE
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            latch_in,
  input  logic [MXCLUSTERS*MXADRBITS-1:0] adr_in,
  input  logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in,
  input  logic [MXCLUSTERS-1:0]           vpf_in,
  output logic [2*(MXADRBITS+MXCNTBITS)+1:0] dout,
  output logic                            dout_valid,
  output logic                            busy,
  output logic [15:0]                     overflow_cnt
);

  localparam int CW = MXADRBITS + MXCNTBITS;   // one cluster word
  localparam int FW = CW * MXCLUSTERS;         // one captured frame
  localparam int LW = 2 * CW + 2;              // one link word

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    w_q, w_d;             // index of the word currently on dout
  logic [FW-1:0] a_q, a_d, b_q, b_d;
  logic          b_v_q, b_v_d;
  logic          drop_pend_q, drop_pend_d;
  logic [15:0]   ovf_q, ovf_d;
  logic [LW-1:0] dout_q, dout_d;
  logic          dv_q, dv_d;

  logic [FW-1:0] frame_in, start_frame;
  logic          frame_done, a_free, start, drop;

  // Link word w of frame f; frame_start and ovf live only in word 0.
  function automatic logic [LW-1:0] mkword(input logic [FW-1:0] f,
                                           input logic [1:0] w,
                                           input logic ovf);
    mkword = {w == 2'd0, (w == 2'd0) & ovf, f[w*2*CW +: 2*CW]};
  endfunction

  // Pack the strobed clusters; empty slots carry the invalid address.
  always_comb begin
    frame_in = '0;
    for (int i = 0; i < MXCLUSTERS; i++)
      frame_in[i*CW +: CW] = vpf_in[i] ?
        {cnt_in[i*MXCNTBITS +: MXCNTBITS], adr_in[i*MXADRBITS +: MXADRBITS]} :
        {{MXCNTBITS{1'b0}}, INVALID_ADR};
  end

  // Slot management, word sequencing and drop accounting.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    a_d         = a_q;
    b_d         = b_q;
    b_v_d       = b_v_q;
    drop_pend_d = drop_pend_q;
    ovf_d       = ovf_q;
    dout_d      = '0;
    dv_d        = 1'b0;
    start       = 1'b0;
    drop        = 1'b0;
    start_frame = a_q;

    frame_done = (state_q == S_SEND) && (w_q == 2'd3);
    a_free     = (state_q == S_IDLE) || frame_done;

    // A buffered frame follows the current one with no idle gap.
    if (frame_done && b_v_q) begin
      start       = 1'b1;
      start_frame = b_q;
      b_v_d       = 1'b0;
    end

    if (latch_in) begin
      if (a_free && !b_v_q) begin
        start       = 1'b1;
        start_frame = frame_in;
      end else if (!b_v_q || frame_done) begin
        // B is empty, or is emptying into A this very cycle.
        b_d   = frame_in;
        b_v_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    if (start) begin
      a_d         = start_frame;
      state_d     = S_SEND;
      w_d         = 2'd0;
      dout_d      = mkword(start_frame, 2'd0, drop_pend_q);
      dv_d        = 1'b1;
      drop_pend_d = 1'b0;
    end else if (state_q == S_SEND && !frame_done) begin
      w_d    = w_q + 2'd1;
      dout_d = mkword(a_q, w_q + 2'd1, 1'b0);
      dv_d   = 1'b1;
    end else if (frame_done) begin
      state_d = S_IDLE;
    end

    // A drop in the same cycle as a frame start keeps the flag pending.
    if (drop) begin
      drop_pend_d = 1'b1;
      if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end
  end

  // State registers with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      w_q         <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      b_v_q       <= 1'b0;
      drop_pend_q <= 1'b0;
      ovf_q       <= 16'd0;
      dout_q      <= '0;
      dv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      a_q         <= a_d;
      b_q         <= b_d;
      b_v_q       <= b_v_d;
      drop_pend_q <= drop_pend_d;
      ovf_q       <= ovf_d;
      dout_q      <= dout_d;
      dv_q        <= dv_d;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dv_q;
  assign busy         = (state_q == S_SEND) || b_v_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_cluster_frame_packer.sv
// Scoreboard bench for cluster_frame_packer: expected link words are queued
// when a strobe is driven and compared as dout_valid words emerge.
module tb_cluster_frame_packer;

  logic        clock = 1'b0;
  logic        reset, latch_in;
  logic [87:0] adr_in;
  logic [23:0] cnt_in;
  logic [7:0]  vpf_in;
  logic [29:0] dout;
  logic        dout_valid, busy;
  logic [15:0] overflow_cnt;

  cluster_frame_packer dut (
    .clock(clock), .reset(reset), .latch_in(latch_in),
    .adr_in(adr_in), .cnt_in(cnt_in), .vpf_in(vpf_in),
    .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clock = ~clock;

  int          total = 0, bad = 0;
  logic [29:0] sbq[$];
  bit          sb_en = 1'b0;
  int          vcount = 0, run = 0, maxrun = 0, busy_low = 0, cyc = 0;
  bit          busy_mon = 1'b0;
  int          starts[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [111:0] ref_frame(input logic [87:0] a, input logic [23:0] c,
                                             input logic [7:0] v);
    logic [111:0] f;
    for (int i = 0; i < 8; i++)
      f[14*i +: 14] = v[i] ? {c[3*i +: 3], a[11*i +: 11]} : {3'd0, 11'h7FE};
    return f;
  endfunction

  function automatic logic [29:0] ref_word(input logic [111:0] f, input int w, input bit ovf);
    return {w == 0, (w == 0) && ovf, f[28*w +: 28]};
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // One-cycle strobe with the given clusters; queue its words when it will be sent.
  task automatic strobe(input logic [87:0] a, input logic [23:0] c, input logic [7:0] v,
                        input bit keep, input bit ovf);
    logic [111:0] f;
    adr_in = a; cnt_in = c; vpf_in = v; latch_in = 1'b1;
    f = ref_frame(a, c, v);
    if (keep) for (int w = 0; w < 4; w++) sbq.push_back(ref_word(f, w, ovf));
    tick();
    latch_in = 1'b0;
    adr_in = {$urandom, $urandom, $urandom};
    cnt_in = $urandom;
    vpf_in = $urandom;
  endtask

  task automatic strobe_rand(input bit keep, input bit ovf);
    strobe({$urandom, $urandom, $urandom}, $urandom, $urandom, keep, ovf);
  endtask

  always @(posedge clock) cyc++;

  // Monitor: scoreboard compare plus valid-run, frame-start and busy tracking.
  always @(negedge clock) begin
    if (dout_valid) begin
      vcount++; run++;
      if (run > maxrun) maxrun = run;
      if (dout[29]) starts.push_back(cyc);
    end else run = 0;
    if (busy_mon && !busy) busy_low++;
    if (sb_en && dout_valid) begin
      if (sbq.size() == 0) chk("sb_extra_word_qsize", sbq.size(), 1);
      else chk("sb_word", dout, sbq.pop_front());
    end
  end

  initial begin
    reset = 1'b1; latch_in = 1'b0; adr_in = '0; cnt_in = '0; vpf_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    @(negedge clock);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow_cnt, 0);
    sb_en = 1'b1;
    tick();

    // Single frame with the two hand-computed clusters.
    vcount = 0;
    strobe({66'h0, 11'd1535, 11'd5}, {18'h0, 3'd7, 3'd2}, 8'h03, 1'b1, 1'b0);
    @(negedge clock);
    chk("single_w0", dout, {1'b1, 1'b0, 14'h3DFF, 14'h1005});
    repeat (8) tick();
    chk("single_vcount", vcount, 4);
    chk("single_sb_left", sbq.size(), 0);

    // Nominal cadence: ten frames, one strobe every 4 cycles.
    vcount = 0; maxrun = 0; busy_low = 0; starts.delete();
    for (int i = 0; i < 10; i++) begin
      strobe_rand(1'b1, 1'b0);
      busy_mon = 1'b1;
      repeat (3) tick();
    end
    busy_mon = 1'b0;
    repeat (6) tick();
    chk("b2b_vcount", vcount, 40);
    chk("b2b_maxrun", maxrun, 40);
    chk("b2b_starts", starts.size(), 10);
    chk("b2b_busy_low", busy_low, 0);
    chk("b2b_ovf", overflow_cnt, 0);
    chk("b2b_sb_left", sbq.size(), 0);

    // Two strobes back to back: second frame follows from B with no gap.
    starts.delete(); maxrun = 0;
    strobe_rand(1'b1, 1'b0);
    strobe_rand(1'b1, 1'b0);
    repeat (10) tick();
    chk("buf_starts", starts.size(), 2);
    if (starts.size() == 2) chk("buf_gap", starts[1] - starts[0], 4);
    chk("buf_maxrun", maxrun, 8);
    chk("buf_ovf", overflow_cnt, 0);
    chk("buf_sb_left", sbq.size(), 0);

    // Three strobes in a row: third dropped, second frame carries ovf.
    strobe_rand(1'b1, 1'b0);
    strobe_rand(1'b1, 1'b1);
    strobe_rand(1'b0, 1'b0);
    repeat (10) tick();
    chk("ovf_cnt1", overflow_cnt, 1);
    strobe_rand(1'b1, 1'b0);
    repeat (8) tick();
    chk("ovf_sb_left", sbq.size(), 0);

    // B full and a strobe exactly on frame_done: B sent next, new frame buffered.
    starts.delete(); vcount = 0; maxrun = 0;
    strobe_rand(1'b1, 1'b0);
    strobe_rand(1'b1, 1'b0);
    repeat (2) tick();
    strobe_rand(1'b1, 1'b0);
    repeat (16) tick();
    chk("coin_vcount", vcount, 12);
    chk("coin_maxrun", maxrun, 12);
    chk("coin_starts", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("coin_gap1", starts[1] - starts[0], 4);
      chk("coin_gap2", starts[2] - starts[1], 4);
    end
    chk("coin_ovf", overflow_cnt, 1);
    chk("coin_sb_left", sbq.size(), 0);

    // Saturation: strobe every cycle until the counter pins at FFFF.
    sb_en = 1'b0;
    latch_in = 1'b1;
    for (int n = 0; n < 90000 && overflow_cnt !== 16'hFFFF; n++) tick();
    chk("sat_reached", overflow_cnt, 16'hFFFF);
    repeat (64) tick();
    chk("sat_hold", overflow_cnt, 16'hFFFF);
    latch_in = 1'b0;
    repeat (12) tick();
    sbq.delete();

    // Reset during word 2 with B occupied; strobe during reset is ignored.
    strobe_rand(1'b0, 1'b0);
    strobe_rand(1'b0, 1'b0);
    tick();
    reset = 1'b1; latch_in = 1'b1;
    @(negedge clock);
    chk("mid_pre_valid", dout_valid, 1);
    chk("mid_pre_busy", busy, 1);
    @(posedge clock); #1;
    reset = 1'b0; latch_in = 1'b0;
    @(negedge clock);
    chk("mid_dout", dout, 0);
    chk("mid_valid", dout_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ovf", overflow_cnt, 0);
    vcount = 0;
    repeat (8) tick();
    chk("mid_after_vcount", vcount, 0);
    chk("mid_after_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
